// File: rtl/wb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package wb_pkg;

    localparam int WB_DEPTH = 4;   // long-latency result FIFO entries
    localparam int WB_DW    = 32;  // register data width
    localparam int WB_AW    = 5;   // register address width

    // One pending register write: destination and data.
    typedef struct packed {
        logic [WB_AW-1:0] wa;
        logic [WB_DW-1:0] wd;
    } wb_req_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_PIPE = 2'd1,
        WB_LU   = 2'd2
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO for long-latency results. The head is read combinationally
// so the arbiter can pop and write it in the same cycle; the array is tiny
// and maps to distributed storage rather than block RAM.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = WB_DEPTH,
    parameter type T     = wb_req_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    // Guard against overflow/underflow even if a caller misbehaves.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count is one bit wider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges in-order pipeline writebacks with
// queued long-latency results onto the single write port, and tracks which
// registers still have a long-latency write outstanding.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_we,
    input  logic [AW-1:0]        pipe_wa,
    input  logic [DW-1:0]        pipe_wd,
    output logic                 pipe_stall,
    input  logic                 lu_valid,
    output logic                 lu_ready,
    input  logic [AW-1:0]        lu_wa,
    input  logic [DW-1:0]        lu_wd,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_wa,
    output logic [(1<<AW)-1:0]   busy,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3
);

    localparam int NREG = 1 << AW;
    localparam int CW   = $clog2(DEPTH) + 1;

    // Same layout as wb_req_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } req_t;

    req_t          lu_req;
    req_t          head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    wb_src_t       sel;

    logic            we3_reg, we3_next;
    logic [AW-1:0]   wa3_reg, wa3_next;
    logic [DW-1:0]   wd3_reg, wd3_next;
    logic [NREG-1:0] busy_reg, busy_next;

    assign lu_req     = '{wa: lu_wa, wd: lu_wd};
    assign lu_ready   = (fifo_count < CW'(DEPTH));
    assign pipe_stall = fifo_full;
    assign push       = lu_valid && lu_ready;
    assign pop        = (sel == WB_LU);

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (lu_req),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pick the write-port owner: a full FIFO must drain before the pipe proceeds.
    always_comb begin
        sel = WB_NONE;
        if (fifo_full) begin
            sel = WB_LU;
        end else if (pipe_we) begin
            sel = WB_PIPE;
        end else if (!fifo_empty) begin
            sel = WB_LU;
        end
    end

    // Next write-port values; writes to register 0 are consumed but never enabled.
    always_comb begin
        we3_next = 1'b0;
        wa3_next = wa3_reg;
        wd3_next = wd3_reg;
        case (sel)
            WB_PIPE: begin
                we3_next = (pipe_wa != '0);
                wa3_next = pipe_wa;
                wd3_next = pipe_wd;
            end
            WB_LU: begin
                we3_next = (head.wa != '0);
                wa3_next = head.wa;
                wd3_next = head.wd;
            end
            default: ;
        endcase
    end

    // Register the write port so the file sees stable values at its negedge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_reg <= 1'b0;
            wa3_reg <= '0;
            wd3_reg <= '0;
        end else begin
            we3_reg <= we3_next;
            wa3_reg <= wa3_next;
            wd3_reg <= wd3_next;
        end
    end

    // Per-register scoreboard update: a new issue outranks a retiring write.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit       = issue_valid && (issue_wa == AW'(gi));
            assign clr_bit       = pop && (head.wa == AW'(gi));
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate

    // Scoreboard state; clears at the same edge the matching write issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign we3  = we3_reg;
    assign wa3  = wa3_reg;
    assign wd3  = wd3_reg;
    assign busy = busy_reg;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter in front of the 32×32 general register file: it is the writer side of the register-file write port (`we3`/`wa3`/`wd3`). It merges in-order pipeline writebacks with out-of-order results from long-latency units (divider, HI/LO moves, load miss) through a small FIFO, and issues at most one register write per cycle. It also maintains a busy-register scoreboard so decode can stall on pending destinations.

## Interface
Parameters:
- `DEPTH`, 4: long-latency result FIFO entries (power of two, ≥2)
- `DW`, 32: data width
- `AW`, 5: register address width

Ports:
- `clk` in 1: clock; all state on posedge (the register file samples on negedge of the same clock)
- `rst` in 1: asynchronous, active-high reset
- `pipe_we` in 1: pipeline writeback request this cycle
- `pipe_wa` in AW: pipeline destination register
- `pipe_wd` in DW: pipeline writeback data
- `pipe_stall` out 1: pipeline writeback refused this cycle; pipeline must hold its request
- `lu_valid` in 1: long-latency result valid
- `lu_ready` out 1: FIFO can accept a result
- `lu_wa` in AW: long-latency destination register
- `lu_wd` in DW: long-latency result data
- `issue_valid` in 1: a long-latency op was issued this cycle
- `issue_wa` in AW: its destination register
- `busy` out 32: scoreboard; bit r is set while register r has a pending long-latency write
- `we3` out 1: register-file write enable (registered)
- `wa3` out AW: register-file write address (registered)
- `wd3` out DW: register-file write data (registered)

## Operation
- Arbitration each posedge, in priority order:
  - FIFO full (count==DEPTH): pop the FIFO head to the write port; `pipe_stall`=1.
  - Else if `pipe_we`: drive the pipeline write.
  - Else if FIFO is non-empty: pop the head.
  - Else: `we3`=0.
- `pipe_stall` = (count==DEPTH), combinational. `pipe_we` while stalled is ignored, not queued.
- `lu_ready` = (count<DEPTH), combinational from current count. Push occurs on `lu_valid && lu_ready`.
- Push and pop in the same cycle are legal at any count, including full (the pop frees the slot only next cycle, so `lu_ready` is already 0 when full).
- Destination 0: the FIFO entry is still pushed and popped, but `we3` stays 0 for it. A pipeline write to register 0 also gives `we3`=0.
- Scoreboard:
  - `issue_valid` with `issue_wa`≠0 sets `busy[issue_wa]` at the next posedge.
  - A FIFO pop with wa≠0 clears that bit at the same edge.
  - If set and clear hit the same register in one cycle, set wins.
  - `busy[0]` is always 0.
- A pipeline write to a register whose busy bit is set is a protocol violation: decode must stall. The bench flags it; the RTL takes no action.
- FIFO is in-order. Pointers wrap modulo DEPTH. Count is an extra bit wide ($clog2(DEPTH)+1).

## Timing
- Reset values: `we3`=0, `wa3`=0, `wd3`=0, `busy`=0, FIFO empty. This gives `lu_ready`=1 and `pipe_stall`=0 when reset deasserts.
- Reset mid-operation discards all queued entries and busy bits immediately (asynchronous).
- Pipeline path latency: `pipe_we` sampled at edge k gives `we3`/`wa3`/`wd3` valid from edge k to k+1. The register file commits on the negedge within that cycle.
- Long-latency path: accepted at edge k, earliest `we3` from edge k+1. There is no same-cycle bypass.
- `busy` clears at the same edge `we3` asserts for that entry, so decode sees the register free in the same cycle the file commits it.

## Structure
- Package `wb_pkg`:
  - `DEPTH`/`DW`/`AW` defaults
  - `typedef struct packed {logic [AW-1:0] wa; logic [DW-1:0] wd;} wb_req_t`
  - source enum `WB_NONE`/`WB_PIPE`/`WB_LU`
- One sub-module: `wb_fifo` (DEPTH×`wb_req_t`, push/pop/count/full/empty, async reset).
- Arbiter select, output registers and scoreboard live in `wb_arbiter`.

## Test plan
- Idle pipe, `lu_valid` with wa=5, wd=0xDEADBEEF at edge 0 -> `we3`=1, `wa3`=5, `wd3`=0xDEADBEEF during cycle 1; `busy[5]` (set by an earlier issue) clears at edge 1.
- `pipe_we` held high every cycle (wa=3), plus 4 LU pushes -> pipe wins until count=4. Then `pipe_stall`=1 and `lu_ready`=0, the FIFO drains one entry, and the pipe resumes.
- `issue_valid` wa=7 in the same cycle as a FIFO pop of wa=7 -> `busy[7]` remains 1.
- LU result to register 0 -> entry popped, `we3` stays 0, `busy`=0.
- Push and pop simultaneously at count=2 for 8 cycles with wrap-around -> data comes out in order, count stays 2.
- Assert `rst` mid-drain with 3 entries queued -> `we3`=0, `busy`=0, `lu_ready`=1 immediately; no stale writes after release.
